// File: rtl/mux_8to1_pkg.sv
// Shared constants for the registered 8:1 lane multiplexer.
package mux_8to1_pkg;
  localparam int NUM_LANES  = 8;
  localparam int SEL_W      = 3;
  localparam int LANE_W_DEF = 1;
endpackage

// File: rtl/mux_8to1_core.sv
// Combinational 8:1 lane selector; lane k sits at in_i[k*LANE_W +: LANE_W].
module mux_8to1_core
  import mux_8to1_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [NUM_LANES*LANE_W-1:0] in_i,
  input  logic [SEL_W-1:0]            sel_i,
  output logic [LANE_W-1:0]           lane_o
);

  // Packed lane view lets sel index lanes directly, no arithmetic on sel.
  logic [NUM_LANES-1:0][LANE_W-1:0] lanes;

  assign lanes  = in_i;
  assign lane_o = lanes[sel_i];

endmodule

// File: rtl/mux_8to1.sv
// Registered 8:1 lane mux: core selector followed by a sync-reset output register.
module mux_8to1
  import mux_8to1_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES*LANE_W-1:0] in,
  input  logic [SEL_W-1:0]            sel,
  output logic [LANE_W-1:0]           out
);

  logic [LANE_W-1:0] out_d;
  logic [LANE_W-1:0] out_q;

  mux_8to1_core #(.LANE_W(LANE_W)) u_core (
    .in_i   (in),
    .sel_i  (sel),
    .lane_o (out_d)
  );

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_mux_8to1.sv
// Randomized and directed checks of mux_8to1 at LANE_W=1 and LANE_W=4 against a shift-based model.
module tb_mux_8to1;
  logic        clk;
  logic        rst;
  logic [7:0]  in1;
  logic [31:0] in4;
  logic [2:0]  sel;
  logic        out1;
  logic [3:0]  out4;

  int checks   = 0;
  int failures = 0;

  mux_8to1 #(.LANE_W(1)) dut1 (.clk(clk), .rst(rst), .in(in1), .sel(sel), .out(out1));
  mux_8to1 #(.LANE_W(4)) dut4 (.clk(clk), .rst(rst), .in(in4), .sel(sel), .out(out4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference: the selected lane is the word shifted down by sel lanes and masked.
  function automatic logic [31:0] ref_out(input logic [31:0] word, input int s, input int w,
                                          input logic r);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return r ? 32'd0 : ((word >> (s * w)) & mask);
  endfunction

  // Advance one edge, then compare both DUTs against the model using the values held at that edge.
  task automatic tick(input string tag);
    logic [31:0] e1, e4;
    e1 = ref_out({24'd0, in1}, int'(sel), 1, rst);
    e4 = ref_out(in4, int'(sel), 4, rst);
    @(posedge clk);
    #1;
    chk(tag, {31'd0, out1}, e1);
    chk({tag, "_w4"}, {28'd0, out4}, e4);
  endtask

  int tbl_sel[7] = '{2, 3, 6, 7, 1, 2, 0};
  int tbl_out[7] = '{0, 1, 0, 0, 0, 0, 1};

  initial begin
    rst = 1'b1; in1 = 8'hFF; in4 = 32'hFFFF_FFFF; sel = 3'd7;
    #2;

    // Reset holds out at zero regardless of in/sel
    for (int i = 0; i < 2; i++) begin
      tick("reset");
      chk("reset_zero", {31'd0, out1}, 32'd0);
    end

    // Pattern table
    rst = 1'b0; in1 = 8'b0000_1001;
    for (int i = 0; i < 7; i++) begin
      sel = tbl_sel[i][2:0];
      tick("pattern");
      chk("pattern_tbl", {31'd0, out1}, tbl_out[i][31:0]);
    end

    // Walking one across every sel code
    for (int k = 0; k < 8; k++) begin
      in1 = 8'd1 << k;
      for (int s = 0; s < 8; s++) begin
        sel = s[2:0];
        tick("walk");
        chk("walk_tbl", {31'd0, out1}, (s == k) ? 32'd1 : 32'd0);
      end
    end

    // Latency and hold between edges
    in1 = 8'h80; sel = 3'd7;
    tick("lat_load");
    chk("lat_one", {31'd0, out1}, 32'd1);
    #3 sel = 3'd0;
    #1 chk("lat_hold_midcycle", {31'd0, out1}, 32'd1);
    tick("lat_next");
    chk("lat_zero", {31'd0, out1}, 32'd0);
    tick("hold_same");
    chk("hold_zero", {31'd0, out1}, 32'd0);

    // Reset mid-stream then resume
    in1 = 8'hFF; sel = 3'd4;
    tick("mid_pre");
    chk("mid_pre_one", {31'd0, out1}, 32'd1);
    rst = 1'b1;
    tick("mid_rst");
    chk("mid_rst_zero", {31'd0, out1}, 32'd0);
    rst = 1'b0;
    tick("mid_resume");
    chk("mid_resume_one", {31'd0, out1}, 32'd1);

    // Wide lanes
    in4 = 32'h7654_3210; sel = 3'd5;
    tick("w4_sel5");
    chk("w4_sel5_const", {28'd0, out4}, 32'h5);
    sel = 3'd7;
    tick("w4_sel7");
    chk("w4_sel7_const", {28'd0, out4}, 32'h7);
    in1 = 8'h5A; sel = 3'd3; in4 = 32'hA5C3_0F96;
    tick("both_change");

    // Randomized stream with sporadic reset
    for (int i = 0; i < 300; i++) begin
      in1 = 8'($urandom);
      in4 = $urandom;
      sel = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 15) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_8to1.md
MUX_8TO1 -- requirements
Module: mux_8to1

Interface
REQ-001 Parameter: LANE_W, default 1, bit width of each of the 8 data lanes.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in  input  8*LANE_W  eight data lanes; lane k occupies bits [k*LANE_W +: LANE_W].
REQ-005 Port: sel  input  3  lane select, binary, 0..7.
REQ-006 Port: out  output  LANE_W  registered selected lane.
REQ-007 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-008 On each rising clk edge with rst low, out SHALL load lane sel of in, i.e. in[sel] for LANE_W=1.
- Applies to all 8 sel codes.
- No code is invalid.
REQ-009 Latency SHALL be exactly 1 clock from sampled in/sel to out.
- No combinational path from in or sel to out.
REQ-010 Changes to in or sel between edges SHALL have no effect on out until the next rising edge.
REQ-011 Simultaneous changes of in and sel before the same edge SHALL produce the new lane of the new in.
REQ-012 out SHALL hold its value across edges when in and sel are unchanged. No enable input exists.
REQ-013 Selection SHALL be a pure data path:
- no arithmetic, no wrap-around, no priority between lanes;
- lane index equals sel interpreted as unsigned.
REQ-014 Unknown (X) on sel SHALL NOT be masked by design. Behaviour under X is undefined.
- Benches SHALL drive known values after reset.

Reset
REQ-015 While rst is high at a rising edge, out SHALL be 0 (all LANE_W bits), regardless of in and sel.
REQ-016 Reset asserted mid-operation SHALL force out to 0 at the next rising edge.
- Normal selection SHALL resume on the first edge after rst deasserts, using in/sel sampled at that edge.
REQ-017 Before the first reset, out is undefined.
- Benches SHALL apply rst for at least one edge before checking.

Structure
REQ-018 A shared package SHALL hold:
- NUM_LANES = 8;
- SEL_W = 3;
- the default LANE_W.
REQ-019 One sub-module is natural: mux_8to1_core.
- Purely combinational 8:1 lane selector, parameterised by LANE_W.
- Instantiated by mux_8to1 and followed by the output register.
REQ-020 The top level SHALL contain only the core instance and the reset-capable output register.

Verification
REQ-021 Reset: rst=1 for 2 edges with in=8'hFF, sel=7 -> out=0 after each edge.
REQ-022 Pattern check, in=8'b00001001 with rst=0, one sel code per edge (out 1 edge later):

| sel | out |
|-----|-----|
| 2   | 0   |
| 3   | 1   |
| 6   | 0   |
| 7   | 0   |
| 1   | 0   |
| 2   | 0   |
| 0   | 1   |

REQ-023 Walking one: in=1<<k for k=0..7 with sel=k -> out=1 one edge later.
- Any sel != k -> out=0.
REQ-024 Latency/hold: in=8'h80, sel=7 at edge N -> out=1 after N.
- At mid-cycle, change sel to 0 -> out stays 1 until edge N+1, then 0.
REQ-025 Reset mid-stream: in=8'hFF, sel=4, out=1; assert rst for one edge -> out=0.
- Deassert rst -> out=1 after the next edge.
REQ-026 LANE_W=4, in=32'h76543210: sel=5 -> out=4'h5; sel=7 -> out=4'h7 (one edge latency each).
